// File: rtl/mcpu_control_fsm.sv
// Multicycle MIPS-style control unit: decodes IR opcode and sequences IF/ID/EXE/MEM/WB.
// Optional performance counters are enabled by defining MCPU_CTRL_PERFCNT_EN.
module mcpu_control_fsm #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [OP_W-1:0]    Opcode,
  input  logic               zero,
  output logic               PCWre,
  output logic [1:0]         PCSrc,
  output logic               IRWre,
  output logic               ExtSel,
  output logic               RegDst,
  output logic               RegWre,
  output logic               WrRegDSrc,
  output logic               ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               mRD,
  output logic               mWR,
  output logic [2:0]         State
`ifdef MCPU_CTRL_PERFCNT_EN
  ,
  output logic [31:0]        CycleCount,
  output logic [31:0]        InstrCount
`endif
);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6'b000001);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(6'b010000);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(6'b010001);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b010010);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(6'b100110);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b110000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b110001);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b110100);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b111000);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(6'b111111);

  typedef enum logic [2:0] {
    S_IF      = 3'b000,
    S_ID      = 3'b001,
    S_EXE_ALU = 3'b110,
    S_EXE_BR  = 3'b101,
    S_EXE_MEM = 3'b010,
    S_MEM     = 3'b011,
    S_WB_ALU  = 3'b111,
    S_WB_LW   = 3'b100
  } state_t;

  state_t state;
  logic   halted;
  logic   is_rtype, is_imm, is_mem, is_legal;

  function automatic logic [ALUOP_W-1:0] alu_op_of(input logic [OP_W-1:0] op);
    case (op)
      OP_SUB:        return ALUOP_W'(3'b001);
      OP_AND:        return ALUOP_W'(3'b010);
      OP_OR, OP_ORI: return ALUOP_W'(3'b011);
      OP_SLT:        return ALUOP_W'(3'b101);
      default:       return ALUOP_W'(3'b000);
    endcase
  endfunction

  always_comb begin
    is_rtype = (Opcode == OP_ADD) || (Opcode == OP_SUB) || (Opcode == OP_OR) ||
               (Opcode == OP_AND) || (Opcode == OP_SLT);
    is_imm   = (Opcode == OP_ADDI) || (Opcode == OP_ORI);
    is_mem   = (Opcode == OP_SW) || (Opcode == OP_LW);
    is_legal = is_rtype || is_imm || is_mem || (Opcode == OP_BEQ) ||
               (Opcode == OP_J) || (Opcode == OP_HALT);
  end

  // HALT is encoded as S_ID plus the halted flag; only Reset leaves it.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state  <= S_IF;
      halted <= 1'b0;
    end else if (!halted) begin
      case (state)
        S_IF: state <= S_ID;
        S_ID: begin
          if (Opcode == OP_J || !is_legal) state <= S_IF;
          else if (Opcode == OP_HALT)      halted <= 1'b1;
          else if (Opcode == OP_BEQ)       state <= S_EXE_BR;
          else if (is_mem)                 state <= S_EXE_MEM;
          else                             state <= S_EXE_ALU;
        end
        S_EXE_ALU: state <= S_WB_ALU;
        S_EXE_BR:  state <= S_IF;
        S_EXE_MEM: state <= S_MEM;
        S_MEM:     state <= (Opcode == OP_LW) ? S_WB_LW : S_IF;
        default:   state <= S_IF;
      endcase
    end
  end

  // ALU controls are held from EXE through WB so the ALU result stays stable.
  always_comb begin
    PCWre     = 1'b0;
    PCSrc     = 2'b00;
    IRWre     = 1'b0;
    ExtSel    = 1'b0;
    RegDst    = 1'b0;
    RegWre    = 1'b0;
    WrRegDSrc = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = '0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    State     = 3'b000;
    if (!Reset) begin
      State = state;
      if (!halted) begin
        case (state)
          S_IF: IRWre = 1'b1;
          S_ID: begin
            if (Opcode == OP_J) begin
              PCWre = 1'b1;
              PCSrc = 2'b10;
            end else if (!is_legal) begin
              PCWre = 1'b1;
            end
          end
          S_EXE_ALU, S_WB_ALU: begin
            ALUOp   = alu_op_of(Opcode);
            ALUSrcB = is_imm;
            ExtSel  = (Opcode == OP_ADDI);
            if (state == S_WB_ALU) begin
              RegWre = 1'b1;
              RegDst = is_rtype;
              PCWre  = 1'b1;
            end
          end
          S_EXE_BR: begin
            ALUOp  = ALUOP_W'(3'b001);
            ExtSel = 1'b1;
            PCWre  = 1'b1;
            PCSrc  = zero ? 2'b01 : 2'b00;
          end
          S_EXE_MEM, S_MEM, S_WB_LW: begin
            ALUOp   = '0;
            ALUSrcB = 1'b1;
            ExtSel  = 1'b1;
            if (state == S_MEM) begin
              if (Opcode == OP_LW) begin
                mRD = 1'b1;
              end else begin
                mWR   = 1'b1;
                PCWre = 1'b1;
              end
            end
            if (state == S_WB_LW) begin
              RegWre    = 1'b1;
              WrRegDSrc = 1'b1;
              PCWre     = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MCPU_CTRL_PERFCNT_EN
  always_ff @(posedge CLK) begin
    if (Reset) begin
      CycleCount <= 32'd0;
      InstrCount <= 32'd0;
    end else begin
      if (!halted) CycleCount <= CycleCount + 32'd1;
      if (PCWre)   InstrCount <= InstrCount + 32'd1;
    end
  end
`endif

endmodule
